// File: rtl/flopoco_fp_pkg.sv
// Shared definitions for the FloPoCo-format floating-point operators:
// exception codes, default formats and the sequential square-root FSM encoding.
package flopoco_fp_pkg;

  localparam int DEF_WE   = 8;
  localparam int DEF_WF   = 23;
  localparam int DEF_BIAS = (2 ** (DEF_WE - 1)) - 1;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CALC  = 2'b01,
    ST_ROUND = 2'b10,
    ST_DONE  = 2'b11
  } sqrt_state_e;

  // {exc, sign} of the square root of a special operand (zero, inf, NaN, negative).
  function automatic logic [2:0] sqrt_special_tag(input logic [1:0] exc, input logic sign);
    logic [2:0] tag;
    case (exc)
      EXC_ZERO: tag = {EXC_ZERO, sign};
      EXC_INF:  tag = sign ? {EXC_NAN, 1'b0} : {EXC_INF, 1'b0};
      EXC_NAN:  tag = {EXC_NAN, 1'b0};
      default:  tag = {EXC_NAN, 1'b0};
    endcase
    return tag;
  endfunction

endpackage

// File: rtl/fp_sqrt_round.sv
// Round-to-nearest-even of the square-root mantissa and result packing.
// Optional inexact flag output is built only when FP_SQRT_FLAGS_EN is defined.
module fp_sqrt_round
  import flopoco_fp_pkg::*;
#(
  parameter int WE = DEF_WE,
  parameter int WF = DEF_WF
) (
  input  logic              special_i,
  input  logic [2:0]        spec_tag_i,
  input  logic [WE-1:0]     exp_i,
  input  logic [WF:0]       root_frac_i,
  input  logic              sticky_i,
  output logic [WE+WF+2:0]  r_o
`ifdef FP_SQRT_FLAGS_EN
  ,
  output logic              inexact_o
`endif
);

  logic              guard_s;
  logic              lsb_s;
  logic              rup_s;
  logic [WE+WF-1:0]  sum_s;

  assign guard_s = root_frac_i[0];
  assign lsb_s   = root_frac_i[1];
  assign rup_s   = guard_s & (sticky_i | lsb_s);

  // Increment on {exp, frac} so a mantissa carry rolls into the exponent.
  assign sum_s = {exp_i, root_frac_i[WF:1]} + {{(WE+WF-1){1'b0}}, rup_s};

  always_comb begin
    if (special_i) begin
      r_o = {spec_tag_i, {(WE+WF){1'b0}}};
    end else begin
      r_o = {EXC_NORMAL, 1'b0, sum_s};
    end
  end

`ifdef FP_SQRT_FLAGS_EN
  always_comb begin
    if (special_i) begin
      inexact_o = 1'b0;
    end else begin
      inexact_o = guard_s | sticky_i;
    end
  end
`endif

endmodule

// File: rtl/fp_sqrt_seq.sv
// Sequential FP square root, restoring recurrence, one root bit per cycle.
// Define FP_SQRT_FLAGS_EN to add the out_invalid / out_inexact flag outputs.
module fp_sqrt_seq
  import flopoco_fp_pkg::*;
#(
  parameter int WE = DEF_WE,
  parameter int WF = DEF_WF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WE+WF+2:0]  in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WE+WF+2:0]  out_r
`ifdef FP_SQRT_FLAGS_EN
  ,
  output logic              out_invalid,
  output logic              out_inexact
`endif
);

  localparam int XW = WE + WF + 3;
  localparam int RW = WF + 2;
  localparam int DW = 2 * RW;
  localparam int MW = RW + 1;
  localparam int TW = MW + 2;
  localparam int CW = $clog2(RW);

  localparam logic [CW-1:0] CNT_LAST = CW'(RW - 1);
  localparam logic [WE:0]   BIAS_W   = {2'b00, {(WE-1){1'b1}}};

  sqrt_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rad_q, rad_d;
  logic [MW-1:0]   rem_q, rem_d;
  logic [RW-1:0]   root_q, root_d;
  logic [WE-1:0]   exp_q, exp_d;
  logic [XW-1:0]   out_r_q, out_r_d;

  logic [1:0]      in_exc_s;
  logic            in_sign_s;
  logic [WE-1:0]   in_exp_s;
  logic [WF-1:0]   in_frac_s;
  logic            in_special_s;
  logic [WE-1:0]   exp_half_s;
  logic [DW-1:0]   rad_init_s;
  logic [TW-1:0]   rem_t_s;
  logic [TW-1:0]   trial_s;
  logic            ge_s;
  logic [MW-1:0]   rem_next_s;
  logic            rnd_special_s;
  logic [XW-1:0]   rnd_r_s;

  assign in_exc_s     = in_x[XW-1:XW-2];
  assign in_sign_s    = in_x[XW-3];
  assign in_exp_s     = in_x[WE+WF-1:WF];
  assign in_frac_s    = in_x[WF-1:0];
  assign in_special_s = (in_exc_s != EXC_NORMAL) | in_sign_s;

  // floor((E + bias) / 2) at WE+1 bits; the quotient always fits back in WE bits.
  assign exp_half_s = WE'(({1'b0, in_exp_s} + BIAS_W) >> 1);

  // An even biased exponent means an odd unbiased one: pre-scale the mantissa by 2.
  assign rad_init_s = in_exp_s[0] ? {2'b01, in_frac_s, {RW{1'b0}}}
                                  : {1'b1, in_frac_s, {(RW+1){1'b0}}};

  assign rem_t_s    = {rem_q, rad_q[DW-1:DW-2]};
  assign trial_s    = {1'b0, root_q, 2'b01};
  assign ge_s       = (rem_t_s >= trial_s);
  assign rem_next_s = ge_s ? (rem_t_s[MW-1:0] - trial_s[MW-1:0]) : rem_t_s[MW-1:0];

  assign rnd_special_s = (state_q == ST_IDLE);

`ifdef FP_SQRT_FLAGS_EN
  logic invalid_q, invalid_d;
  logic inexact_q, inexact_d;
  logic in_invalid_s;
  logic rnd_inexact_s;

  assign in_invalid_s = in_sign_s & ((in_exc_s == EXC_NORMAL) | (in_exc_s == EXC_INF));
`endif

  fp_sqrt_round #(
    .WE (WE),
    .WF (WF)
  ) u_round (
    .special_i   (rnd_special_s),
    .spec_tag_i  (sqrt_special_tag(in_exc_s, in_sign_s)),
    .exp_i       (exp_q),
    .root_frac_i (root_q[WF:0]),
    .sticky_i    (|rem_q),
    .r_o         (rnd_r_s)
`ifdef FP_SQRT_FLAGS_EN
    ,
    .inexact_o   (rnd_inexact_s)
`endif
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CW{1'b0}};
      rad_q     <= {DW{1'b0}};
      rem_q     <= {MW{1'b0}};
      root_q    <= {RW{1'b0}};
      exp_q     <= {WE{1'b0}};
      out_r_q   <= {XW{1'b0}};
`ifdef FP_SQRT_FLAGS_EN
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rad_q     <= rad_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      exp_q     <= exp_d;
      out_r_q   <= out_r_d;
`ifdef FP_SQRT_FLAGS_EN
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    exp_d     = exp_q;
    out_r_d   = out_r_q;
`ifdef FP_SQRT_FLAGS_EN
    invalid_d = invalid_q;
    inexact_d = inexact_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_special_s) begin
            out_r_d   = rnd_r_s;
`ifdef FP_SQRT_FLAGS_EN
            invalid_d = in_invalid_s;
            inexact_d = 1'b0;
`endif
            state_d   = ST_DONE;
          end else begin
            rad_d   = rad_init_s;
            rem_d   = {MW{1'b0}};
            root_d  = {RW{1'b0}};
            exp_d   = exp_half_s;
            cnt_d   = CNT_LAST;
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        rad_d  = {rad_q[DW-3:0], 2'b00};
        rem_d  = rem_next_s;
        root_d = {root_q[RW-2:0], ge_s};
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_ROUND;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_ROUND: begin
        out_r_d   = rnd_r_s;
`ifdef FP_SQRT_FLAGS_EN
        invalid_d = 1'b0;
        inexact_d = rnd_inexact_s;
`endif
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_r     = out_r_q;
`ifdef FP_SQRT_FLAGS_EN
  assign out_invalid = invalid_q;
  assign out_inexact = inexact_q;
`endif

endmodule

// File: doc/fp_sqrt_seq.md
# fp_sqrt_seq

Iterative floating-point square root for the FloPoCo-format datapath. It accepts one operand in the 34-bit exception-tagged format (WE=8, WF=23) produced and consumed by the squarer, multiplier and adder operators, and returns the correctly rounded square root, round-to-nearest-even. It sits beside the FP squarer in the non-linear-equation accelerator and provides the inverse operation for iterative solvers. A restoring digit recurrence produces one root bit per cycle, with a valid/ready handshake on both sides.

## Interface
- WE, 8: exponent width.
- WF, 23: fraction width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand; high only in IDLE.
- in_x  in  WE+WF+3  operand, laid out as exc[WE+WF+2:WE+WF+1], sign[WE+WF], exp, frac.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_r  out  WE+WF+3  result, same layout as in_x.
- out_invalid, out_inexact  out  1 each  present only with FP_SQRT_FLAGS_EN.

## Operation
- Exception codes: 00 zero, 01 normal, 10 infinity, 11 NaN.
- Special cases bypass the recurrence and go IDLE->DONE:
  - zero gives zero with the input sign preserved (so -0 gives -0).
  - +inf gives +inf.
  - -inf, NaN, or a negative normal give NaN with sign 0.
- Normal inputs, with biased exponent E and bias B = 2^(WE-1)-1:
  - result exponent = floor((E+B)/2), computed at WE+1 bits; it cannot overflow or underflow.
  - radicand = {1,frac}, shifted left one place when E is even.
  - the radicand is treated as fixed point with 2 integer bits, zero-extended to 2*(WF+2) bits.
- The recurrence runs WF+2 = 25 iterations. Each iteration produces one root bit by trial-subtracting from the partial remainder (restoring).
- The root is 25 bits: 1 integer bit, 23 fraction bits (lsb at index 1), and a guard bit (index 0). Sticky = final remainder != 0.
- Rounding:
  - round-up = guard & (sticky | lsb).
  - the increment is added to the concatenation {exp, frac}, so a mantissa carry propagates into the exponent.
  - exc = 01, sign = 0.
- FSM:
  - IDLE: accept when in_valid & in_ready. A special input goes to DONE; a normal input goes to CALC.
  - CALC: the iteration counter runs 24 down to 0, then the FSM goes to ROUND.
  - ROUND: out_r is registered and the FSM goes to DONE.
  - DONE: out_valid is high. On out_ready the FSM goes to IDLE.
- Handshake and output hold:
  - out_r and out_valid are held stable while out_ready is low.
  - no new operand is accepted before the result has been taken; back-to-back operations are not overlapped.
  - in_x is captured at the accepting edge. It may change afterwards without affecting the result.
- Reset asserted in any state:
  - the FSM returns to IDLE immediately and any in-flight operation is discarded.
  - out_valid = 0, out_r = 0, flags = 0.
  - in_ready = 1 once reset is released.

## Timing
- Normal operand: out_valid rises 27 edges after the accepting edge (25 CALC cycles + ROUND + DONE entry).
- Special operand: out_valid rises 1 edge after the accepting edge.
- in_ready is low from the accepting edge until the edge on which out_valid & out_ready are both high. It is high again in the following cycle.
- The block does not accept a new operand on the same edge as it completes the result handshake.

## Configuration
- FP_SQRT_FLAGS_EN defined:
  - out_invalid = 1 when a NaN result is generated from a non-NaN input (a negative normal or -inf).
  - out_inexact = guard | sticky for normal inputs, and 0 otherwise.
  - both flags are registered together with out_r.
- FP_SQRT_FLAGS_EN undefined: both flag ports and their logic are absent. out_r is bit-identical to the flagged build.

## Structure
- Shared package flopoco_fp_pkg holds:
  - the exception-code constants;
  - the WE and WF defaults and the bias;
  - the FSM state encoding.
- Sub-module fp_sqrt_round (combinational) holds the round-up decision, the {exp, frac} increment, and exception/result packing. The top level holds the FSM, the counter, and the remainder/root registers.

## Test plan
- sqrt(4.0): exp 0x81, frac 0 -> exp 0x80, frac 0, out_inexact=0, latency 27.
- sqrt(2.0): exp 0x80, frac 0 -> exp 0x7F, frac 0x3504F3, out_inexact=1.
- Largest normal, exp 0xFE, frac 0x7FFFFF -> exp 0xBE, frac 0x7FFFFF. The result lies just below the rounding tie, so no carry.
- Special inputs:
  - -1.0 -> exc 11, out_invalid=1, latency 1.
  - -0 -> exc 00, sign 1.
  - +inf -> exc 10.
- Hold out_ready low for 10 cycles after out_valid -> out_r is stable, in_ready stays 0, and the next operand is accepted only after the handshake.
- Pulse rst_n low at CALC cycle 10 -> out_valid=0 and in_ready=1 after reset release. The next sqrt(2.0) is then correct.
